// File: rtl/psg_pkg.sv
// Shared constants and types for the dual-PSG (TurboSound) CPU bus controller.
// Port decode only looks at a[15], a[14] and a[1]; all other address bits are don't-care.
package psg_pkg;

   localparam logic [15:0] PORT_MASK  = 16'hC002;
   localparam logic [15:0] FFFD_MATCH = 16'hC000;
   localparam logic [15:0] BFFD_MATCH = 16'h8000;

   // FFFD data values 8'hFF / 8'hFE pick the chip instead of a register address.
   localparam logic [7:0] SEL_PSG0   = 8'hFF;
   localparam logic [7:0] SEL_PSG1   = 8'hFE;
   localparam logic [6:0] SEL_PREFIX = SEL_PSG0[7:1];

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } wr_state_t;

   function automatic logic port_hit(input logic [15:0] addr, input logic [15:0] match);
      return (addr & PORT_MASK) == match;
   endfunction

endpackage

// File: rtl/psg_ce_gen.sv
// Free-running clock-enable divider: ce is high one cycle in every CEDIV.
// ce_pre leads ce by one cycle so callers can register outputs that line up with ce.
module psg_ce_gen #(
   parameter int CEDIV = 32
) (
   input  logic clock,
   input  logic reset,
   output logic ce,
   output logic ce_pre
);

   localparam int CW = (CEDIV > 2) ? $clog2(CEDIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CEDIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(CEDIV - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign ce     = (cnt == LAST);
   assign ce_pre = (cnt == PRE);

endmodule

// File: rtl/psg_bus_controller.sv
// Z80 I/O front end for two AY-3-8912 style PSG cores: chip select, per-chip
// register address latches, ce-aligned write strobes and CPU read-back.
//
// state | meaning
// IDLE  | no register write outstanding
// PEND  | BFFD write captured in wdata/tgt, waiting for the next ce
module psg_bus_controller
   import psg_pkg::*;
#(
   parameter int CEDIV = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iorq,
   input  logic        rd,
   input  logic        wr,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   input  logic [7:0]  q0,
   input  logic [7:0]  q1,
   output logic        ce,
   output logic        sel,
   output logic [3:0]  addr0,
   output logic [3:0]  addr1,
   output logic [7:0]  wdata,
   output logic        we0,
   output logic        we1,
   output logic [7:0]  dout,
   output logic        oe
);

   logic      ce_pre;
   logic      iow;
   logic      iow_q;
   logic      wr_evt;
   logic      fffd_hit;
   logic      bffd_hit;
   logic      fffd_evt;
   logic      bffd_ok;
   logic      rd_hit;
   logic      inv0;
   logic      inv1;
   logic      sel_inv;
   logic      tgt;
   logic      we_set;
   logic      we_tgt;
   wr_state_t state;
   wr_state_t state_nxt;

   psg_ce_gen #(
      .CEDIV (CEDIV)
   ) u_ce_gen (
      .clock  (clock),
      .reset  (reset),
      .ce     (ce),
      .ce_pre (ce_pre)
   );

   assign iow      = ~iorq & ~wr;
   assign wr_evt   = iow & ~iow_q;
   assign fffd_hit = port_hit(a, FFFD_MATCH);
   assign bffd_hit = port_hit(a, BFFD_MATCH);
   assign fffd_evt = wr_evt & fffd_hit;
   assign sel_inv  = sel ? inv1 : inv0;
   assign bffd_ok  = wr_evt & bffd_hit & ~sel_inv;
   assign rd_hit   = ~iorq & ~rd & fffd_hit;

   // The strobe is registered on the ce_pre cycle so it lands on the ce cycle.
   // An event on ce_pre itself is therefore served by the very next ce, while
   // an event on the ce cycle waits a full period.
   always_comb begin
      state_nxt = state;
      we_set    = 1'b0;
      we_tgt    = bffd_ok ? sel : tgt;
      case (state)
         IDLE: begin
            if (bffd_ok) begin
               if (ce_pre) begin
                  we_set = 1'b1;
               end else begin
                  state_nxt = PEND;
               end
            end
         end
         PEND: begin
            if (ce_pre) begin
               we_set    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         iow_q <= 1'b0;
         we0   <= 1'b0;
         we1   <= 1'b0;
         wdata <= 8'h00;
         tgt   <= 1'b0;
      end else begin
         state <= state_nxt;
         iow_q <= iow;
         we0   <= we_set & ~we_tgt;
         we1   <= we_set & we_tgt;
         if (bffd_ok) begin
            wdata <= d;
            tgt   <= sel;
         end
      end
   end

   // FFFD writes: FF/FE switch the selected chip, anything else loads its address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel   <= 1'b0;
         addr0 <= 4'h0;
         addr1 <= 4'h0;
         inv0  <= 1'b0;
         inv1  <= 1'b0;
      end else if (fffd_evt) begin
         if (d[7:1] == SEL_PREFIX) begin
            sel <= ~d[0];
         end else if (sel) begin
            addr1 <= d[3:0];
            inv1  <= |d[7:4];
         end else begin
            addr0 <= d[3:0];
            inv0  <= |d[7:4];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         oe   <= 1'b0;
         dout <= 8'h00;
      end else begin
         oe <= rd_hit;
         if (!rd_hit) begin
            dout <= 8'h00;
         end else if (sel_inv) begin
            dout <= 8'hFF;
         end else begin
            dout <= sel ? q1 : q0;
         end
      end
   end

endmodule

// File: tb/tb_psg_bus_controller.sv
// Bench for psg_bus_controller: directed vector table, multi-cycle corner
// sequences and random Z80 bus traffic checked every cycle against a model.
module tb_psg_bus_controller;

   localparam int CEDIV = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        iorq  = 1'b1;
   logic        rd    = 1'b1;
   logic        wr    = 1'b1;
   logic [15:0] a     = 16'h0000;
   logic [7:0]  d     = 8'h00;
   logic [7:0]  q0    = 8'h00;
   logic [7:0]  q1    = 8'h00;
   logic        ce, sel, we0, we1, oe;
   logic [3:0]  addr0, addr1;
   logic [7:0]  wdata, dout;

   psg_bus_controller #(.CEDIV(CEDIV)) dut (
      .clock (clock),
      .reset (reset),
      .iorq  (iorq),
      .rd    (rd),
      .wr    (wr),
      .a     (a),
      .d     (d),
      .q0    (q0),
      .q1    (q1),
      .ce    (ce),
      .sel   (sel),
      .addr0 (addr0),
      .addr1 (addr1),
      .wdata (wdata),
      .we0   (we0),
      .we1   (we1),
      .dout  (dout),
      .oe    (oe)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;

   // Reference model: cycle index since reset, chip state, pending write.
   int         k;
   bit         m_iow_q, m_sel, m_pend, m_tgt, m_oe;
   bit         m_inv [2];
   logic [3:0] m_addr [2];
   logic [7:0] m_wdata, m_dout;
   int         cnt_we0, cnt_we1, cnt_ce;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, k);
         end
      end
   endtask

   function automatic bit is_fffd(input logic [15:0] x);
      return x[15] && x[14] && !x[1];
   endfunction

   function automatic bit is_bffd(input logic [15:0] x);
      return x[15] && !x[14] && !x[1];
   endfunction

   task automatic model_reset();
      k = 0;
      m_iow_q = 0; m_sel = 0; m_pend = 0; m_tgt = 0; m_oe = 0;
      m_inv[0] = 0; m_inv[1] = 0;
      m_addr[0] = 4'h0; m_addr[1] = 4'h0;
      m_wdata = 8'h00; m_dout = 8'h00;
   endtask

   // One clock cycle: compare at negedge, advance the model on this cycle's inputs.
   task automatic step();
      bit ce_exp, strobe, iow, evt, rd_hit;
      @(negedge clock);
      ce_exp = (k % CEDIV) == (CEDIV - 1);
      strobe = ce_exp && m_pend;
      if (strobe) m_pend = 0;
      chk("ce", ce, ce_exp);
      chk("we0", we0, strobe && !m_tgt);
      chk("we1", we1, strobe && m_tgt);
      chk("sel", sel, m_sel);
      chk("addr0", addr0, m_addr[0]);
      chk("addr1", addr1, m_addr[1]);
      chk("wdata", wdata, m_wdata);
      chk("oe", oe, m_oe);
      if (m_oe) chk("dout", dout, m_dout);
      if (we0) cnt_we0++;
      if (we1) cnt_we1++;
      if (ce)  cnt_ce++;
      iow     = !iorq && !wr;
      evt     = iow && !m_iow_q;
      m_iow_q = iow;
      rd_hit  = !iorq && !rd && is_fffd(a);
      m_oe    = rd_hit;
      m_dout  = m_inv[m_sel] ? 8'hFF : (m_sel ? q1 : q0);
      if (evt && is_fffd(a)) begin
         if (d[7:1] == 7'h7F) begin
            m_sel = !d[0];
         end else begin
            m_addr[m_sel] = d[3:0];
            m_inv[m_sel]  = |d[7:4];
         end
      end else if (evt && is_bffd(a) && !m_inv[m_sel]) begin
         m_wdata = d;
         m_tgt   = m_sel;
         m_pend  = 1;
      end
      k++;
      @(posedge clock);
      #1;
   endtask

   task automatic bus_idle(input int n);
      iorq = 1'b1; rd = 1'b1; wr = 1'b1;
      repeat (n) begin
         q0 = 8'($urandom);
         q1 = 8'($urandom);
         step();
      end
   endtask

   task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
      a = addr; d = data; iorq = 1'b0; wr = 1'b0; rd = 1'b1;
      repeat (hold) step();
      iorq = 1'b1; wr = 1'b1;
      step();
   endtask

   task automatic io_read(input logic [15:0] addr, input logic [7:0] v0, input logic [7:0] v1,
                          input int hold, output logic [7:0] ds, output logic os);
      a = addr; q0 = v0; q1 = v1; iorq = 1'b0; rd = 1'b1; wr = 1'b1;
      step();
      rd = 1'b0;
      repeat (hold) step();
      ds = dout;
      os = oe;
      iorq = 1'b1; rd = 1'b1;
      step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ce"}, ce, 0);
      chk({tag, " sel"}, sel, 0);
      chk({tag, " addr0"}, addr0, 0);
      chk({tag, " addr1"}, addr1, 0);
      chk({tag, " wdata"}, wdata, 0);
      chk({tag, " we0"}, we0, 0);
      chk({tag, " we1"}, we1, 0);
      chk({tag, " dout"}, dout, 0);
      chk({tag, " oe"}, oe, 0);
   endtask

   task automatic sync_phase(input int ph);
      for (int t = 0; t < CEDIV && (k % CEDIV) != ph; t++) bus_idle(1);
   endtask

   typedef struct {
      bit          rd;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  q0;
      logic [7:0]  q1;
      bit          e_sel;
      logic [3:0]  e_a0;
      logic [3:0]  e_a1;
      logic [7:0]  e_wd;
      bit          e_oe;
      logic [7:0]  e_dout;
      int          e_we0;
      int          e_we1;
   } vec_t;

   vec_t tbl [11];

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0]  ds, rdv;
      logic        os;
      logic [15:0] ra;
      int          kind, hold;

      //        rd  a         d      q0     q1     sel a0    a1    wd     oe dout   we0 we1
      tbl[0]  = '{0, 16'hFFFD, 8'h07, 8'h00, 8'h00, 0, 4'h7, 4'h0, 8'h00, 0, 8'h00, 0, 0};
      tbl[1]  = '{0, 16'hBFFD, 8'h38, 8'h00, 8'h00, 0, 4'h7, 4'h0, 8'h38, 0, 8'h00, 1, 0};
      tbl[2]  = '{0, 16'hFFFD, 8'hFE, 8'h00, 8'h00, 1, 4'h7, 4'h0, 8'h38, 0, 8'h00, 0, 0};
      tbl[3]  = '{0, 16'hC000, 8'h0B, 8'h00, 8'h00, 1, 4'h7, 4'hB, 8'h38, 0, 8'h00, 0, 0};
      tbl[4]  = '{0, 16'h8000, 8'h55, 8'h00, 8'h00, 1, 4'h7, 4'hB, 8'h55, 0, 8'h00, 0, 1};
      tbl[5]  = '{1, 16'hFFFD, 8'h00, 8'h12, 8'h55, 1, 4'h7, 4'hB, 8'h55, 1, 8'h55, 0, 0};
      tbl[6]  = '{0, 16'hFFFD, 8'hFF, 8'h00, 8'h00, 0, 4'h7, 4'hB, 8'h55, 0, 8'h00, 0, 0};
      tbl[7]  = '{0, 16'hFFFD, 8'h1F, 8'h00, 8'h00, 0, 4'hF, 4'hB, 8'h55, 0, 8'h00, 0, 0};
      tbl[8]  = '{0, 16'hBFFD, 8'hAA, 8'h00, 8'h00, 0, 4'hF, 4'hB, 8'h55, 0, 8'h00, 0, 0};
      tbl[9]  = '{1, 16'hFFFD, 8'h00, 8'h33, 8'h44, 0, 4'hF, 4'hB, 8'h55, 1, 8'hFF, 0, 0};
      tbl[10] = '{1, 16'hBFFD, 8'h00, 8'h66, 8'h77, 0, 4'hF, 4'hB, 8'h55, 0, 8'h00, 0, 0};

      model_reset();
      @(negedge clock);
      chk_all_zero("reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      model_reset();

      // Idle after reset: ce at cycles 31, 63, 95.
      cnt_ce = 0; cnt_we0 = 0; cnt_we1 = 0;
      bus_idle(100);
      chk("idle ce count", cnt_ce, 3);
      chk("idle strobes", cnt_we0 + cnt_we1, 0);

      for (int i = 0; i < 11; i++) begin
         cnt_we0 = 0; cnt_we1 = 0;
         if (tbl[i].rd) begin
            io_read(tbl[i].a, tbl[i].q0, tbl[i].q1, 3, ds, os);
            chk($sformatf("v%0d oe", i), os, tbl[i].e_oe);
            if (tbl[i].e_oe) chk($sformatf("v%0d dout", i), ds, tbl[i].e_dout);
         end else begin
            io_write(tbl[i].a, tbl[i].d, 3);
         end
         bus_idle(40);
         chk($sformatf("v%0d sel", i), sel, tbl[i].e_sel);
         chk($sformatf("v%0d addr0", i), addr0, tbl[i].e_a0);
         chk($sformatf("v%0d addr1", i), addr1, tbl[i].e_a1);
         chk($sformatf("v%0d wdata", i), wdata, tbl[i].e_wd);
         chk($sformatf("v%0d we0 count", i), cnt_we0, tbl[i].e_we0);
         chk($sformatf("v%0d we1 count", i), cnt_we1, tbl[i].e_we1);
      end

      // Two BFFD writes inside one ce period: one strobe, last data wins.
      io_write(16'hFFFD, 8'h01, 2);
      bus_idle(2);
      sync_phase(0);
      cnt_we0 = 0; cnt_we1 = 0;
      io_write(16'hBFFD, 8'h11, 2);
      bus_idle(1);
      io_write(16'hBFFD, 8'h22, 2);
      bus_idle(40);
      chk("double we0 count", cnt_we0, 1);
      chk("double we1 count", cnt_we1, 0);
      chk("double wdata", wdata, 8'h22);
      chk("double addr0", addr0, 4'h1);

      // Event near ce: the model checks the exact strobe cycle (latency 1..CEDIV).
      for (int p = 29; p < 33; p++) begin
         sync_phase(p % CEDIV);
         cnt_we0 = 0; cnt_we1 = 0;
         io_write(16'hBFFD, 8'(p), 1);
         bus_idle(40);
         chk($sformatf("phase%0d we0 count", p % CEDIV), cnt_we0, 1);
         chk($sformatf("phase%0d wdata", p % CEDIV), wdata, 8'(p));
      end

      // Reset while a write is pending drops it and clears all state.
      io_write(16'hFFFD, 8'hFE, 1);
      io_write(16'hFFFD, 8'h09, 1);
      sync_phase(0);
      io_write(16'hBFFD, 8'h5A, 1);
      reset = 1'b1;
      @(negedge clock);
      chk_all_zero("midpend reset");
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
      cnt_we0 = 0; cnt_we1 = 0;
      bus_idle(40);
      chk("post-reset strobes", cnt_we0 + cnt_we1, 0);
      chk("post-reset sel", sel, 0);
      chk("post-reset addr1", addr1, 0);
      chk("post-reset wdata", wdata, 0);

      // Random bus traffic against the model.
      for (int i = 0; i < 400; i++) begin
         kind = $urandom_range(0, 5);
         hold = $urandom_range(1, 5);
         ra   = 16'($urandom);
         case (kind)
            0: begin
               ra = {2'b11, ra[13:2], 1'b0, ra[0]};
               case ($urandom_range(0, 3))
                  0:       io_write(ra, 8'hFF, hold);
                  1:       io_write(ra, 8'hFE, hold);
                  2:       io_write(ra, {4'h0, 4'($urandom)}, hold);
                  default: io_write(ra, 8'($urandom), hold);
               endcase
            end
            1: io_write({2'b10, ra[13:2], 1'b0, ra[0]}, 8'($urandom), hold);
            2: io_read({2'b11, ra[13:2], 1'b0, ra[0]}, 8'($urandom), 8'($urandom), hold, rdv, os);
            3: io_read({2'b10, ra[13:2], 1'b0, ra[0]}, 8'($urandom), 8'($urandom), hold, rdv, os);
            4: io_write(ra, 8'($urandom), hold);
            default: io_read(ra, 8'($urandom), 8'($urandom), hold, rdv, os);
         endcase
         bus_idle($urandom_range(0, 35));
      end
      bus_idle(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psg_bus_controller.md
Name: psg_bus_controller

Overview:
- Sequences CPU access to the two AY-3-8912-compatible PSG cores that produce the a1/b1/c1 and a2/b2/c2 channel levels for the audio mixer (TurboSound arrangement).
- Decodes Z80 I/O writes and reads at ports FFFD (select/address) and BFFD (data).
- Keeps the chip select and a per-chip register address latch.
- Generates the PSG clock enable, and issues write strobes aligned to that enable so the PSG cores only sample on enabled cycles.

Parameters:
- CEDIV, 32, clock cycles per PSG clock-enable pulse; 56 MHz / 32 = 1.75 MHz; must be ≥ 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- iorq  in  1  Z80 IORQ, active low, synchronous to clock
- rd  in  1  Z80 RD, active low
- wr  in  1  Z80 WR, active low
- a  in  16  Z80 address bus
- d  in  8  Z80 data bus (write data)
- q0  in  8  read data from PSG 0 (register addr0)
- q1  in  8  read data from PSG 1 (register addr1)
- ce  out  1  PSG clock enable, one cycle every CEDIV
- sel  out  1  selected PSG (0/1)
- addr0  out  4  register address for PSG 0
- addr1  out  4  register address for PSG 1
- wdata  out  8  register write data, shared by both PSGs
- we0  out  1  write strobe for PSG 0, coincident with ce
- we1  out  1  write strobe for PSG 1, coincident with ce
- dout  out  8  CPU read data
- oe  out  1  dout valid; CPU bus mux drives dout when high

Behaviour:
- Reset (async, active-high) clears all outputs and state to 0: sel = 0, addr0 = addr1 = 0, wdata = 0, we0 = we1 = 0, ce = 0, dout = 0, oe = 0, divider = 0, FSM in IDLE.

Decode:
- Port FFFD: a[15] = 1, a[14] = 1, a[1] = 0.
- Port BFFD: a[15] = 1, a[14] = 0, a[1] = 0.
- Other address bits are ignored.

Write detect:
- iow = ~iorq & ~wr, registered each cycle.
- A write event is the single cycle where iow is 1 now and was 0 on the previous cycle.
- The address is qualified on that cycle only. One event per I/O cycle, however long the cycle is held.

FFFD write event:
- If d[7:1] = 7'b1111111, then sel <= ~d[0] (FF selects PSG 0, FE selects PSG 1). Address latches are unchanged.
- Otherwise, the selected chip's address latch <= d[3:0], and its invalid flag <= |d[7:4].

BFFD write event:
- Captures wdata <= d and tgt <= sel, then enters PEND.
- If the target chip's invalid flag is set, the write is discarded: no strobe and no state change.

ce divider:
- Counter runs 0..CEDIV-1 and wraps.
- ce = 1 on the cycle the counter equals CEDIV-1.

Write FSM:
- IDLE: on a valid BFFD event, go to PEND.
- PEND: on a ce cycle, assert we[tgt] for exactly that cycle (registered, so it is aligned with ce), then go to IDLE.
- Latency: the strobe comes 1..CEDIV cycles after the event.
- An event and ce on the same cycle in IDLE: capture now, strobe on the next ce. No combinational shortcut.
- A new BFFD event while in PEND overwrites wdata/tgt and stays in PEND (last write wins).
- An FFFD select/address event while in PEND does not alter the captured tgt. The pending write still uses the address latch value current at strobe time. Software must not reprogram the address before the strobe; this ≤ CEDIV window is shorter than any Z80 I/O cycle.

Read:
- oe = 1 while ~iorq & ~rd and the address decodes FFFD (registered, 1-cycle latency).
- dout = sel ? q1 : q0.
- If the selected chip's invalid flag is set, dout = FF.
- Reads of BFFD: oe = 0.

Other rules:
- we0 and we1 are never high together, and never high without ce.
- Reset mid-PEND drops the pending write.

Decomposition:
- Shared package (psg_pkg):
  - port decode constants: FFFD mask/match and BFFD mask/match, expressed on a[15], a[14], a[1];
  - select codes FF/FE;
  - FSM state enum IDLE/PEND.
- One sub-module, psg_ce_gen: the parameterised CEDIV divider producing ce. It is reusable for other audio timing.
- The FSM, latches and decode stay in psg_bus_controller.

Test Plan:
1. Reset, then idle 100 cycles → ce pulses every 32 cycles starting at cycle 31; all other outputs 0; sel = 0.
2. OUT FFFD,07 then OUT BFFD,38 → addr0 = 7; wdata = 38; we0 high for one cycle coincident with the next ce; we1 stays 0.
3. OUT FFFD,FE; OUT FFFD,0B; OUT BFFD,55; IN FFFD with q1 = 55 → sel = 1; addr1 = B; we1 strobe; addr0 unchanged; dout = 55 with oe = 1.
4. Two BFFD writes (11 then 22) before the next ce → exactly one strobe, wdata = 22.
5. OUT FFFD,1F then OUT BFFD,AA → no strobe; IN FFFD returns FF.
6. Assert reset while in PEND (before ce) → no strobe after release; sel, addr0/addr1 and wdata all 0.
